// File: rtl/dl_lshift_pipe.sv
// dl_lshift_pipe
//   Pipelined, elastic left shifter. One registered stage per shift-amount
//   bit: stage i shifts its incoming operand by 2**i when the corresponding
//   shamt bit is set. Valid/ready handshakes on both sides give one result per
//   cycle at full throughput, with bubble-collapsing backpressure.
//
//   Build option: define DL_LSHIFT_ROTATE_EN to add the sh_type port and per-stage
//   type registers (1 = rotate left, 0 = logical shift left). Without it the
//   block is a pure logical left shifter.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous clear of every in-flight item (wins over accept)
//   in_valid   operand present
//   in_ready   stage 0 can accept this cycle
//   in_data    operand, NUM_BITS wide
//   in_shamt   shift amount, NUM_SHIFT_BITS wide
//   sh_type    0 = shift left, 1 = rotate left (DL_LSHIFT_ROTATE_EN only)
//   out_valid  result present
//   out_ready  downstream accepts result
//   out_data   shifted result, held stable while out_valid & ~out_ready
module dl_lshift_pipe #(
  parameter  int unsigned NUM_BITS       = 32,
  localparam int unsigned NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_BITS-1:0]       in_data,
  input  logic [NUM_SHIFT_BITS-1:0] in_shamt,
`ifdef DL_LSHIFT_ROTATE_EN
  input  logic                      sh_type,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_BITS-1:0]       out_data
);

  localparam int unsigned W    = NUM_BITS;
  localparam int unsigned S    = NUM_SHIFT_BITS;
  localparam int unsigned LAST = S - 1;

  // Stage registers. shamt_q holds the not-yet-consumed shift bits, realigned
  // so the next stage always tests bit 0.
  logic [S-1:0]  valid_q;
  logic [W-1:0]  data_q  [S];
  logic [S-1:0]  shamt_q [S];
`ifdef DL_LSHIFT_ROTATE_EN
  logic [S-1:0]  type_q;
`endif

  // Per-stage incoming contents and the shifted operand to be captured.
  logic [S-1:0]  stg_valid;
  logic [W-1:0]  stg_data    [S];
  logic [S-1:0]  stg_shamt   [S];
  logic [W-1:0]  stg_shifted [S];
`ifdef DL_LSHIFT_ROTATE_EN
  logic [S-1:0]  stg_type;
`endif

  logic [S-1:0]  adv;
  logic          accept;

  // Stage i may advance unless it and every stage after it are full and the
  // sink is stalling; flattened form of adv[i] = adv[i+1] | ~valid[i].
  for (genvar i = 0; i < S; i++) begin : g_adv
    assign adv[i] = out_ready | ~(&valid_q[S-1:i]);
  end

  assign in_ready  = adv[0];
  assign accept    = in_valid & in_ready;
  assign out_valid = valid_q[LAST];
  assign out_data  = data_q[LAST];

  // Stage input selection and fixed-distance shift/rotate.
  for (genvar i = 0; i < S; i++) begin : g_stage
    localparam int unsigned STEP = 32'd1 << i;

    if (i == 0) begin : g_first
      assign stg_valid[i] = accept;
      assign stg_data[i]  = in_data;
      assign stg_shamt[i] = in_shamt;
`ifdef DL_LSHIFT_ROTATE_EN
      assign stg_type[i]  = sh_type;
`endif
    end else begin : g_next
      assign stg_valid[i] = valid_q[i-1];
      assign stg_data[i]  = data_q[i-1];
      assign stg_shamt[i] = shamt_q[i-1];
`ifdef DL_LSHIFT_ROTATE_EN
      assign stg_type[i]  = type_q[i-1];
`endif
    end

`ifdef DL_LSHIFT_ROTATE_EN
    // Rotation re-inserts the bits pushed out of the MSB end at the LSB end.
    always_comb begin
      stg_shifted[i] = stg_data[i];
      if (stg_shamt[i][0]) begin
        if (stg_type[i]) begin
          stg_shifted[i] = (stg_data[i] << STEP) | (stg_data[i] >> (W - STEP));
        end else begin
          stg_shifted[i] = stg_data[i] << STEP;
        end
      end
    end
`else
    always_comb begin
      stg_shifted[i] = stg_data[i];
      if (stg_shamt[i][0]) begin
        stg_shifted[i] = stg_data[i] << STEP;
      end
    end
`endif
  end

  // Pipeline registers: flush drops all items, otherwise each stage loads when
  // it may advance and holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < S; i++) begin
        data_q[i]  <= '0;
        shamt_q[i] <= '0;
      end
`ifdef DL_LSHIFT_ROTATE_EN
      type_q  <= '0;
`endif
    end else begin
      for (int i = 0; i < S; i++) begin
        if (flush) begin
          valid_q[i] <= 1'b0;
        end else if (adv[i]) begin
          valid_q[i] <= stg_valid[i];
          data_q[i]  <= stg_shifted[i];
          shamt_q[i] <= stg_shamt[i] >> 1;
`ifdef DL_LSHIFT_ROTATE_EN
          type_q[i]  <= stg_type[i];
`endif
        end
      end
    end
  end

  // The final stage's control tail has no consumer.
  logic unused_tail;
`ifdef DL_LSHIFT_ROTATE_EN
  assign unused_tail = ^{shamt_q[LAST], type_q[LAST]};
`else
  assign unused_tail = ^shamt_q[LAST];
`endif

endmodule

// File: tb/tb_dl_lshift_pipe.sv
// tb_dl_lshift_pipe
//   Self-checking bench for dl_lshift_pipe (NUM_BITS = 32). A negedge monitor
//   pushes the reference result of every accepted operand into a queue and pops
//   and compares it when the result handshakes out; scenario tasks add their
//   own latency, handshake and hold checks.
module tb_dl_lshift_pipe;

  localparam int unsigned W = 32;
  localparam int unsigned S = 5;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [S-1:0] in_shamt;
  logic         sh_type;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  int n_checks;
  int n_fail;
  int n_out;
  logic [W-1:0] exp_q [$];

  dl_lshift_pipe #(.NUM_BITS(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
`ifdef DL_LSHIFT_ROTATE_EN
    .sh_type   (sh_type),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: shift or rotate left by s.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [S-1:0] s,
                                         input logic t);
    logic [W-1:0] r;
    r = d << s;
    if (t && s != 0) r = r | (d >> (W - int'(s)));
    return r;
  endfunction

  // Scoreboard: outputs checked before the accept of the same edge is recorded.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready && !flush) begin
        n_checks++;
        n_out++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: out_data=%h emitted with nothing outstanding", out_data);
        end else begin
          logic [W-1:0] exp;
          exp = exp_q.pop_front();
          if (out_data !== exp) begin
            n_fail++;
            $display("FAIL sb_data: out_data=%h expected=%h", out_data, exp);
          end
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(in_data, in_shamt, sh_type));
    end
  end

  task automatic test_reset();
    #12;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hold: out_valid=%b out_data=%h in_ready=%b expected 0/0/1",
               out_valid, out_data, in_ready);
    end
    @(posedge clk); #3 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h0000_0001; in_shamt = 5'd31;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== (k == 5)) begin
        n_fail++;
        $display("FAIL single_latency: cycle %0d out_valid=%b expected %b", k, out_valid, k == 5);
      end
    end
    n_checks++;
    if (out_data !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL single_data: out_data=%h expected 80000000", out_data);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int first, last, cnt;
    first = -1; last = -1; cnt = 0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          @(posedge clk); #1;
          in_valid = 1'b1; in_data = 32'hF0F0_F0F0; in_shamt = S'(k);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 25; c++) begin
          @(negedge clk);
          if (out_valid) begin
            if (first < 0) first = c;
            last = c;
            cnt++;
          end
        end
      end
    join
    n_checks++;
    if (cnt != 8 || (last - first) != 7) begin
      n_fail++;
      $display("FAIL stream_run: %0d valid cycles spanning %0d, expected 8 consecutive",
               cnt, last - first + 1);
    end
  endtask

  task automatic test_backpressure();
    int acc, k, out_before;
    logic [W-1:0] held;
    logic held_seen;
    acc = 0; k = 0; held_seen = 1'b0; held = '0;
    out_before = n_out;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h1234_5678; in_shamt = 5'd1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (in_ready) begin
        acc++;
        k++;
      end
      if (out_valid) begin
        if (!held_seen) begin
          held = out_data;
          held_seen = 1'b1;
        end else begin
          n_checks++;
          if (out_data !== held) begin
            n_fail++;
            $display("FAIL bp_hold: out_data=%h changed from %h while stalled", out_data, held);
          end
        end
      end
      @(posedge clk); #1;
      in_data = 32'h1234_5678 + W'(k);
      in_shamt = S'(k + 1);
    end
    n_checks++;
    if (acc != 5 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_capacity: accepts=%0d in_ready=%b out_valid=%b expected 5/0/1",
               acc, in_ready, out_valid);
    end
    n_checks++;
    if (held !== 32'h2468_ACF0) begin
      n_fail++;
      $display("FAIL bp_head: held out_data=%h expected 2468acf0", held);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || (n_out - out_before) != 5) begin
      n_fail++;
      $display("FAIL bp_drain: outstanding=%0d emitted=%0d expected 0/5",
               exp_q.size(), n_out - out_before);
    end
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 32'hA5A5_0000 + W'(k); in_shamt = S'(k);
      @(posedge clk); #1;
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_shamt = 5'd3;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_clear: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_drop: out_valid=%b expected 0 at cycle %0d", out_valid, c);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 32'h0000_00FF; in_shamt = 5'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== (k == 5)) begin
        n_fail++;
        $display("FAIL flush_next_latency: cycle %0d out_valid=%b expected %b", k, out_valid, k == 5);
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 32'h0F00_000F + W'(k); in_shamt = S'(k + 2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: out_valid=%b out_data=%h in_ready=%b expected 0/0/1",
               out_valid, out_data, in_ready);
    end
    @(posedge clk); @(posedge clk); #3 rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_stale: out_valid=%b out_data=%h at cycle %0d", out_valid, out_data, c);
      end
    end
  endtask

`ifdef DL_LSHIFT_ROTATE_EN
  task automatic test_rotate();
    logic [W-1:0] got [2];
    int n;
    n = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h8000_0001; in_shamt = 5'd4; sh_type = 1'b1;
    @(posedge clk); #1;
    sh_type = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 12 && n < 2; c++) begin
      @(negedge clk);
      if (out_valid) begin
        got[n] = out_data;
        n++;
      end
    end
    n_checks++;
    if (n != 2 || got[0] !== 32'h0000_0018 || got[1] !== 32'h0000_0010) begin
      n_fail++;
      $display("FAIL rotate: got %0d results %h %h expected 00000018 00000010", n, got[0], got[1]);
    end
  endtask
`endif

  initial begin
    n_checks = 0; n_fail = 0; n_out = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0;
    sh_type = 1'b0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
`ifdef DL_LSHIFT_ROTATE_EN
    test_rotate();
`endif
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
